// File: rtl/serial_word_rx.sv
// Bit-serial word receiver: framed LSB-first deserializer with parity/stop
// checking and a small valid/ready output FIFO.
module serial_word_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_valid,
  input  logic              ser_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overflow,
  output logic              busy
);

  localparam int CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CNTW-1:0]   count;

  logic stop_stb;
  logic par_ok;
  logic push;
  logic pop;
  logic full;
  logic accept;

  assign stop_stb  = (state == STOP) && ser_valid;
  assign par_ok    = (PARITY_EN == 0) || !((^shreg) ^ par);
  assign push      = stop_stb && ser_data && par_ok;
  assign pop       = out_valid && out_ready;
  assign full      = (count == CNTW'(FIFO_DEPTH));
  assign accept    = push && (!full || pop);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      par   <= 1'b0;
    end else if (ser_valid) begin
      unique case (state)
        IDLE: begin
          if (!ser_data) begin
            state <= DATA;
            cnt   <= '0;
            shreg <= '0;
            par   <= 1'b0;
          end
        end
        DATA: begin
          shreg[cnt] <= ser_data;
          cnt        <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1))
            state <= (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          par   <= ser_data;
          state <= STOP;
        end
        STOP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stop-bit failure masks the parity check for the same word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= stop_stb && !ser_data;
      parity_err <= stop_stb && ser_data && !par_ok;
      overflow   <= push && !accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= shreg;
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: vector table for single frames plus
// hand sequences for FIFO full/overflow and mid-frame reset.
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_valid;
  logic       ser_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_rx #(
    .DATA_W    (8),
    .PARITY_EN (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       pflip;
    logic       stop;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change just after a negedge; the next posedge samples them.
  task automatic send_bit(input logic b, input int gap);
    ser_valid = 1'b1;
    ser_data  = b;
    @(negedge clk);
    ser_valid = 1'b0;
    ser_data  = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_body(input logic [7:0] d, input logic pflip,
                           input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit((^d) ^ pflip, gap);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip,
                            input logic stop, input int gap);
    send_body(d, pflip, gap);
    send_bit(stop, 0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_perr"}, parity_err, 0);
    chk({name, "_ferr"}, frame_err, 0);
    chk({name, "_ovf"}, overflow, 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

    rst_n     = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk_quiet("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Idle-line ones never start a frame.
    send_bit(1'b1, 1);
    chk("idle_busy", busy, 0);

    foreach (vecs[i]) begin
      send_body(vecs[i].data, vecs[i].pflip, i % 3);
      chk($sformatf("v%0d_busy", i), busy, 1);
      send_bit(vecs[i].stop, 0);
      chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
      chk($sformatf("v%0d_perr", i), parity_err, vecs[i].e_perr);
      chk($sformatf("v%0d_ferr", i), frame_err, vecs[i].e_ferr);
      chk($sformatf("v%0d_ovf", i), overflow, 0);
      chk($sformatf("v%0d_busy2", i), busy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid2", i), out_valid, 0);
      chk_quiet($sformatf("v%0d_post", i));
    end

    // Overflow: five words into a four-entry FIFO with no consumer.
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b0, 1'b1, 1);
      chk($sformatf("ovf_f%0d", k), overflow, (k == 5) ? 1 : 0);
    end
    @(negedge clk);
    chk("ovf_pulse_end", overflow, 0);
    chk("ovf_hold_data", out_data, 8'h01);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_drain_v%0d", k), out_valid, 1);
      chk($sformatf("ovf_drain_d%0d", k), out_data, 8'(k));
      @(negedge clk);
    end
    chk("ovf_empty", out_valid, 0);
    chk("ovf_empty_data", out_data, 0);

    // Full FIFO, pop in the stop-bit cycle makes room for the new word.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b0, 1'b1, 0);
    send_body(8'h06, 1'b0, 0);
    out_ready = 1'b1;
    send_bit(1'b1, 0);
    out_ready = 1'b0;
    chk("full_pop_ovf", overflow, 0);
    chk("full_pop_head", out_data, 8'h02);
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp;
      exp = (k == 3) ? 8'h06 : 8'(k + 2);
      chk($sformatf("full_drain_v%0d", k), out_valid, 1);
      chk($sformatf("full_drain_d%0d", k), out_data, exp);
      @(negedge clk);
    end
    chk("full_empty", out_valid, 0);

    // Reset mid-frame with a word held in the FIFO.
    out_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 0);
    send_bit(1'b0, 3);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 3);
    chk("mid_busy", busy, 1);
    chk("mid_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk_quiet("arst");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'h5A);
    chk_quiet("post_rst");
    @(negedge clk);
    chk("post_rst_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Receive side of the bit-serial word link used between blocks in `rtl/`.
- Samples a framed, LSB-first serial stream qualified by a per-bit strobe and reassembles DATA_W-bit words.
- Checks parity and the stop bit, and buffers good words in a small FIFO.
- Presents words on a valid/ready output port to the consuming module.

Parameters:
- DATA_W, 8: payload bits per word.
- PARITY_EN, 1: 1 means an even-parity bit follows the data bits; 0 means no parity bit.
- FIFO_DEPTH, 4: output buffer entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ser_valid  input  1  high marks a cycle that carries one serial bit.
- ser_data  input  1  serial bit value; sampled only when ser_valid=1. The line idles at 1.
- out_valid  output  1  the FIFO head word is available.
- out_ready  input  1  the consumer accepts the head word.
- out_data  output  DATA_W  the FIFO head word.
- parity_err  output  1  one-cycle pulse: the received word failed parity and was dropped.
- frame_err  output  1  one-cycle pulse: the stop bit was 0 and the word was dropped.
- overflow  output  1  one-cycle pulse: a good word was dropped because the FIFO was full.
- busy  output  1  the FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE; bit counter, shift register and FIFO pointers clear.
  - out_valid=0, out_data=0, parity_err=0, frame_err=0, overflow=0, busy=0.
  - Reset mid-frame discards the partial word. FIFO contents are lost.
- Cycles with ser_valid=0 never advance the FSM. Frame bits may be spaced by any number of idle cycles.
- FSM states:
  - IDLE: ser_valid=1 with ser_data=0 is a start bit; go to DATA with bit counter=0. ser_data=1 stays in IDLE.
  - DATA: each strobed bit shifts in at position counter, LSB first, and the counter increments. After bit DATA_W-1, go to PARITY if PARITY_EN=1, otherwise to STOP.
  - PARITY: capture the strobed bit and go to STOP. Even parity: the XOR of the data bits and the parity bit must equal 0.
  - STOP: the strobed bit is the stop bit; return to IDLE.
    - Stop bit 0: pulse frame_err. frame_err takes precedence; parity_err is not asserted for the same word. The word is dropped.
    - Stop bit 1 with bad parity: pulse parity_err and drop the word.
    - Stop bit 1 with good parity: push the word.
  - A start bit is never taken in the same cycle as a stop bit. The next start bit needs a later strobe.
- Error pulses are registered and assert in the cycle after the stop-bit cycle.
- Latency: a word pushed into an empty FIFO gives out_valid=1 in the cycle after the stop-bit cycle.
- FIFO:
  - Pop when out_valid && out_ready.
  - A push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop happens in the same cycle.
  - Otherwise the word is dropped and overflow pulses in the next cycle. Stored words are never overwritten.
  - Simultaneous push and pop leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits wide.
- Output handshake:
  - out_data comes straight from the head entry and is stable while out_valid=1 and out_ready=0.
  - out_valid stays high until the word is accepted.
  - out_data is 0 when the FIFO is empty.
- busy is 1 in DATA, PARITY and STOP.

Test Plan:
- DATA_W=8, PARITY_EN=1: strobe 0, 1,0,1,0,0,1,0,1, parity 0, stop 1 with out_ready=1 → out_valid=1 with out_data=0xA5 for exactly one cycle, starting the cycle after the stop bit; no error pulses.
- Same frame with parity bit 1 → parity_err pulses one cycle after the stop bit; out_valid stays 0.
- Frame 0x3C with good parity and stop bit 0 → frame_err pulses once, parity_err stays 0, no word is pushed; a following good 0x11 frame outputs 0x11.
- out_ready=0, send 5 good frames 0x01..0x05 with FIFO_DEPTH=4 → overflow pulses after frame 5; then raise out_ready → outputs 0x01,0x02,0x03,0x04 in order, then out_valid=0.
- FIFO full (0x01..0x04 held), out_ready=1 during the stop-bit cycle of frame 0x06 → 0x01 pops, 0x06 is accepted, no overflow; the drain order is 0x02,0x03,0x04,0x06.
- Assert rst_n=0 after the fourth data bit with ser_valid gaps of 3 cycles between bits → busy=0 and all outputs 0 immediately; after release, a full 0x5A frame is received correctly.
